// File: rtl/program_fetch_pkg.sv
// Shared widths, defaults and redirect encoding for the program fetch stage.
package program_fetch_pkg;

  localparam int unsigned PC_W    = 11;
  localparam int unsigned INSTR_W = 14;

  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT    = 14'h0000;
  localparam int unsigned        STACK_DEPTH_DEFAULT = 8;

  // Ordered lowest to highest priority.
  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_SKIP,
    REDIR_BRANCH,
    REDIR_CALL,
    REDIR_RET
  } redir_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stack.sv
// Circular hardware return stack; overflow/underflow sticky flags exist only when
// PROGRAM_FETCH_STACK_FLAGS_EN is defined, otherwise the flag outputs are tied low.
module fetch_stack
  import program_fetch_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [PC_W-1:0]               push_data_i,
  output logic [PC_W-1:0]               top_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(STACK_DEPTH):0]  count_o,
  output logic                          ovf_o,
  output logic                          unf_o
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem_q [STACK_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0] count_q, count_d;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign full_o  = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pointer always moves; only the occupancy count saturates at full/empty.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) count_d = count_q + CNT_W'(1);
    end else if (pop_i) begin
      ptr_d = top_idx;
      if (!empty_o) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

`ifdef PROGRAM_FETCH_STACK_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_i && full_o) ovf_q <= 1'b1;
      if (pop_i && !push_i && empty_o) unf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
`endif

endmodule

// File: rtl/program_fetch.sv
// Instruction fetch stage: PC, instruction register, return stack and redirect flush.
// Optional sticky stack flags are enabled with PROGRAM_FETCH_STACK_FLAGS_EN.
module program_fetch
  import program_fetch_pkg::*;
#(
  parameter int unsigned         STACK_DEPTH = STACK_DEPTH_DEFAULT,
  parameter logic [INSTR_W-1:0]  NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    Rom_addr_out,
  input  logic [INSTR_W-1:0] Rom_data_in,
  input  logic               Stall,
  input  logic               Branch_en,
  input  logic               Call_en,
  input  logic               Ret_en,
  input  logic               Skip_en,
  input  logic [PC_W-1:0]    Branch_addr,
  output logic [INSTR_W-1:0] Ir_out,
  output logic               Ir_valid,
  output logic [PC_W-1:0]    Ir_pc,
  output logic               Stack_ovf,
  output logic               Stack_unf
);

  redir_e              redir;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]     ir_pc_q;
  logic [PC_W-1:0]     stack_top;
  logic                push, pop;
  logic                stack_full, stack_empty;
  logic [$clog2(STACK_DEPTH):0] stack_count;
  logic                unused_stack_status;

  always_comb begin
    redir = REDIR_NONE;
    if (Ret_en)         redir = REDIR_RET;
    else if (Call_en)   redir = REDIR_CALL;
    else if (Branch_en) redir = REDIR_BRANCH;
    else if (Skip_en)   redir = REDIR_SKIP;
  end

  // Stack only moves on an edge that actually advances the pipeline.
  assign push = !reset && !Stall && (redir == REDIR_CALL);
  assign pop  = !reset && !Stall && (redir == REDIR_RET);

  always_comb begin
    pc_d       = pc_inc(pc_q);
    ir_d       = Rom_data_in;
    ir_valid_d = 1'b1;
    case (redir)
      REDIR_RET: begin
        pc_d       = stack_top;
        ir_d       = NOP_WORD;
        ir_valid_d = 1'b0;
      end
      REDIR_CALL, REDIR_BRANCH: begin
        pc_d       = Branch_addr;
        ir_d       = NOP_WORD;
        ir_valid_d = 1'b0;
      end
      REDIR_SKIP: begin
        ir_d       = NOP_WORD;
        ir_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      ir_q       <= NOP_WORD;
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
    end else if (!Stall) begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= pc_q;
    end
  end

  fetch_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc(ir_pc_q)),
    .top_o       (stack_top),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .count_o     (stack_count),
    .ovf_o       (Stack_ovf),
    .unf_o       (Stack_unf)
  );

  assign unused_stack_status = ^{stack_full, stack_empty, stack_count};

  assign Rom_addr_out = pc_q;
  assign Ir_out       = ir_q;
  assign Ir_valid     = ir_valid_q;
  assign Ir_pc        = ir_pc_q;

endmodule
